// File: rtl/hero_bus_arbiter.sv
// -----------------------------------------------------------------------------
// hero_bus_arbiter
//
// Shares one registered hero write bus among NUM_REQ requesters. Each
// requester presents a transaction as zero or more VALID cycles followed by one
// DONE cycle. Arbitration is round-robin at transaction granularity. Once a
// requester wins, it owns the bus until its DONE is accepted, so transactions
// never interleave.
//
// Optional feature, enabled by defining HERO_BUS_ARB_WATCHDOG_EN:
//   This feature adds a watchdog on owner idle time. If the owner presents IDLE
//   for TIMEOUT_CYCLES consecutive cycles during a burst, the arbiter ends the
//   burst. It injects a DONE with zero data and pulses wd_abort.
//   Without the macro, wd_abort is tied to 0 and a burst can last indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_cycle_type    per-requester cycle type (2 bits each):
//                     0=IDLE, 1=VALID, 2=DONE, 3=IDLE
//   req_wdat          per-requester write data (HERO_WIDTH bits each)
//   req_clk_en        per-requester clock enable
//   req_rdy           the requester's current cycle is accepted this clock
//   bus_rdy           downstream accepts the current bus cycle
//   bus_cycle_type    registered cycle type toward the bag datapath
//   bus_wdat          registered write data
//   bus_clk_en        registered clock enable
//   bus_src_id        requester that owns the current bus cycle
//   wd_abort          one-cycle pulse that marks an injected watchdog DONE
// -----------------------------------------------------------------------------
module hero_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int HERO_WIDTH     = 36,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*2-1:0]          req_cycle_type,
  input  logic [NUM_REQ*HERO_WIDTH-1:0] req_wdat,
  input  logic [NUM_REQ-1:0]            req_clk_en,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic                          bus_rdy,
  output logic [1:0]                    bus_cycle_type,
  output logic [HERO_WIDTH-1:0]         bus_wdat,
  output logic                          bus_clk_en,
  output logic [ID_W-1:0]               bus_src_id,
  output logic                          wd_abort
);

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // This function adds off to base and wraps the result modulo NUM_REQ.
  // The callers keep off below NUM_REQ, so one subtraction is enough.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-requester views of the flattened input buses
  // ---------------------------------------------------------------------------
  logic [1:0]            ct     [NUM_REQ];
  logic [HERO_WIDTH-1:0] wd     [NUM_REQ];
  logic [NUM_REQ-1:0]    active;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ct[g]     = req_cycle_type[2*g +: 2];
    assign wd[g]     = req_wdat[HERO_WIDTH*g +: HERO_WIDTH];
    // Code 3 is treated as IDLE, so a requester is active only on VALID or DONE.
    assign active[g] = (ct[g] == CT_VALID) || (ct[g] == CT_DONE);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [1:0]            type_q, type_d;
  logic [HERO_WIDTH-1:0] wdat_q, wdat_d;
  logic                  clk_en_q, clk_en_d;
  logic [ID_W-1:0]       src_q, src_d;

`ifdef HERO_BUS_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_abort_q, wd_abort_d;
`endif

  // ---------------------------------------------------------------------------
  // Output-stage acceptance
  // ---------------------------------------------------------------------------
  logic out_busy;
  logic can_acc;

  assign out_busy = (type_q != CT_IDLE);
  // The output register can load a new cycle when it is empty or when
  // downstream takes the cycle it is showing now.
  assign can_acc  = !out_busy || bus_rdy;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first active requester at or after rr_ptr
  // ---------------------------------------------------------------------------
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default at
    // the top. Any path that skips an assignment would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && active[wrap_add(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, grant and bus-load logic
  // ---------------------------------------------------------------------------
  logic [1:0] owner_ct;
  assign owner_ct = ct[owner_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    type_d   = type_q;
    wdat_d   = wdat_q;
    clk_en_d = clk_en_q;
    src_d    = src_q;
    req_rdy  = '0;
`ifdef HERO_BUS_ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    wd_abort_d = 1'b0;
`endif

    // When the output can advance, it shows a bubble unless a cycle is
    // accepted below. bus_src_id keeps its last value across bubbles.
    if (can_acc) begin
      type_d   = CT_IDLE;
      wdat_d   = '0;
      clk_en_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
`ifdef HERO_BUS_ARB_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        if (pick_found && can_acc) begin
          req_rdy[pick_idx] = 1'b1;
          type_d   = ct[pick_idx];
          wdat_d   = wd[pick_idx];
          clk_en_d = req_clk_en[pick_idx];
          src_d    = pick_idx;
          if (ct[pick_idx] == CT_VALID) begin
            state_d = ARB_BURST;
            owner_d = pick_idx;
          end else begin
            // A lone DONE is a complete transaction, so the pointer moves on.
            rr_ptr_d = wrap_add(pick_idx, 1);
          end
        end
      end

      ARB_BURST: begin
        if (owner_ct == CT_VALID || owner_ct == CT_DONE) begin
`ifdef HERO_BUS_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          if (can_acc) begin
            req_rdy[owner_q] = 1'b1;
            type_d   = owner_ct;
            wdat_d   = wd[owner_q];
            clk_en_d = req_clk_en[owner_q];
            src_d    = owner_q;
            if (owner_ct == CT_DONE) begin
              state_d  = ARB_IDLE;
              rr_ptr_d = wrap_add(owner_q, 1);
            end
          end
        end else begin
          // The owner is idle inside its burst. The bubble load above already
          // covers the bus. Only the watchdog has anything to do here.
`ifdef HERO_BUS_ARB_WATCHDOG_EN
          if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            // The counter saturates at the limit. The forced DONE waits until
            // the output stage can take it.
            if (can_acc) begin
              type_d     = CT_DONE;
              wdat_d     = '0;
              clk_en_d   = 1'b0;
              src_d      = owner_q;
              wd_abort_d = 1'b1;
              wd_cnt_d   = '0;
              state_d    = ARB_IDLE;
              rr_ptr_d   = wrap_add(owner_q, 1);
            end
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`endif
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the values from before the edge, whatever the order of
    // the statements.
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      type_q   <= CT_IDLE;
      wdat_q   <= '0;
      clk_en_q <= 1'b0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      type_q   <= type_d;
      wdat_q   <= wdat_d;
      clk_en_q <= clk_en_d;
      src_q    <= src_d;
    end
  end

`ifdef HERO_BUS_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q   <= '0;
      wd_abort_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_abort_q <= wd_abort_d;
    end
  end

  assign wd_abort = wd_abort_q;
`else
  assign wd_abort = 1'b0;
`endif

  assign bus_cycle_type = type_q;
  assign bus_wdat       = wdat_q;
  assign bus_clk_en     = clk_en_q;
  assign bus_src_id     = src_q;

endmodule

// File: tb/tb_hero_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hero_bus_arbiter
//
// Self-checking bench for hero_bus_arbiter with NUM_REQ=4 and HERO_WIDTH=36.
// A behavioural reference model tracks three things: the free-or-owned bus,
// the round-robin pointer and the registered output. Every cycle it predicts
// req_rdy and the next bus contents from the arbitration rules.
// Directed scenarios run first, followed by a long randomized run with random
// transactions, idle gaps and downstream back-pressure.
// Define HERO_BUS_ARB_WATCHDOG_EN to model and exercise the watchdog as well.
// -----------------------------------------------------------------------------
module tb_hero_bus_arbiter;

  localparam int N   = 4;
  localparam int W   = 36;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*2-1:0] req_cycle_type;
  logic [N*W-1:0] req_wdat;
  logic [N-1:0]   req_clk_en;
  logic [N-1:0]   req_rdy;
  logic           bus_rdy;
  logic [1:0]     bus_cycle_type;
  logic [W-1:0]   bus_wdat;
  logic           bus_clk_en;
  logic [IDW-1:0] bus_src_id;
  logic           wd_abort;

  always #5 clk = ~clk;

  // Per-requester drive values, packed onto the DUT buses.
  logic [1:0] d_t [N];
  logic [W-1:0] d_w [N];
  logic d_e [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_cycle_type[2*g +: 2] = d_t[g];
    assign req_wdat[W*g +: W]       = d_w[g];
    assign req_clk_en[g]            = d_e[g];
  end

  hero_bus_arbiter #(
    .NUM_REQ       (N),
    .HERO_WIDTH    (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_cycle_type(req_cycle_type),
    .req_wdat      (req_wdat),
    .req_clk_en    (req_clk_en),
    .req_rdy       (req_rdy),
    .bus_rdy       (bus_rdy),
    .bus_cycle_type(bus_cycle_type),
    .bus_wdat      (bus_wdat),
    .bus_clk_en    (bus_clk_en),
    .bus_src_id    (bus_src_id),
    .wd_abort      (wd_abort)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_ptr, m_owner, m_src, m_idle;   // m_owner < 0: the bus is free
  logic [1:0] m_type;
  logic [W-1:0] m_wdat;
  logic       m_en, m_abort;

  int         n_ptr, n_owner, n_src, n_idle;
  logic [1:0] n_type;
  logic [W-1:0] n_wdat;
  logic       n_en, n_abort;
  logic [N-1:0] exp_rdy;

  function automatic bit is_req(input logic [1:0] t);
    return (t == 2'd1) || (t == 2'd2);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_src = 0; m_idle = 0;
    m_type = 2'd0; m_wdat = '0; m_en = 1'b0; m_abort = 1'b0;
    exp_rdy = '0;
  endtask

  task automatic model_take(input int i);
    exp_rdy[i] = 1'b1;
    n_type = d_t[i]; n_wdat = d_w[i]; n_en = d_e[i]; n_src = i;
  endtask

  task automatic model_eval();
    bit can;
    int pick;
    can = (m_type == 2'd0) || bus_rdy;
    n_ptr = m_ptr; n_owner = m_owner; n_src = m_src; n_idle = m_idle;
    n_type = m_type; n_wdat = m_wdat; n_en = m_en; n_abort = 1'b0;
    exp_rdy = '0;
    if (can) begin n_type = 2'd0; n_wdat = '0; n_en = 1'b0; end
    if (m_owner < 0) begin
      n_idle = 0;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && is_req(d_t[(m_ptr + k) % N])) pick = (m_ptr + k) % N;
      if (pick >= 0 && can) begin
        model_take(pick);
        if (d_t[pick] == 2'd1) n_owner = pick;
        else n_ptr = (pick + 1) % N;
      end
    end else if (is_req(d_t[m_owner])) begin
      n_idle = 0;
      if (can) begin
        model_take(m_owner);
        if (d_t[m_owner] == 2'd2) begin
          n_owner = -1; n_ptr = (m_owner + 1) % N;
        end
      end
    end else begin
`ifdef HERO_BUS_ARB_WATCHDOG_EN
      if (m_idle >= TO) begin
        if (can) begin
          n_type = 2'd2; n_wdat = '0; n_en = 1'b0; n_src = m_owner;
          n_abort = 1'b1; n_owner = -1; n_ptr = (m_owner + 1) % N; n_idle = 0;
        end
      end else n_idle = m_idle + 1;
`endif
    end
  endtask

  task automatic model_commit();
    m_ptr = n_ptr; m_owner = n_owner; m_src = n_src; m_idle = n_idle;
    m_type = n_type; m_wdat = n_wdat; m_en = n_en; m_abort = n_abort;
  endtask

  // ---------------------------------------------------------------------------
  // One clock: at the falling edge, check the registered outputs and req_rdy
  // against the model. Then advance the model at the rising edge. The task
  // returns 1 time unit after the rising edge, ready for the next drive.
  // ---------------------------------------------------------------------------
  bit         logging = 1'b0;
  logic [1:0] log_t [$];
  int         log_s [$];

  task automatic step();
    @(negedge clk);
    if (logging) begin
      log_t.push_back(bus_cycle_type);
      log_s.push_back(int'(bus_src_id));
    end
    check("bus_cycle_type", bus_cycle_type, m_type);
    check("bus_wdat", bus_wdat, m_wdat);
    check("bus_clk_en", bus_clk_en, m_en);
    if (m_type != 2'd0) check("bus_src_id", bus_src_id, m_src);
    check("wd_abort", wd_abort, m_abort);
    model_eval();
    check("req_rdy", req_rdy, exp_rdy);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int         g_left [N];     // VALIDs still to send before the DONE; -1 = none
  logic [1:0] sq [N][$];      // scripted cycle sequences

  task automatic rand_data(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    d_w[i] = r[W-1:0];
    d_e[i] = r[63];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      d_t[i] = 2'd0; d_w[i] = '0; d_e[i] = 1'b0; g_left[i] = -1;
      sq[i].delete();
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_type", bus_cycle_type, 2'd0);
    check("rst_wdat", bus_wdat, '0);
    check("rst_clk_en", bus_clk_en, 1'b0);
    check("rst_src", bus_src_id, '0);
    check("rst_wd_abort", wd_abort, 1'b0);
    check("rst_req_rdy", req_rdy, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_rdy = 1'b1;
  endtask

  task automatic present(input int i);
    d_t[i] = (g_left[i] > 0) ? 2'd1 : 2'd2;
    rand_data(i);
  endtask

  task automatic go_idle(input int i);
    d_t[i] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0;
    rand_data(i);
  endtask

  // Random requester behaviour that keeps the requester contract: an
  // unaccepted VALID or DONE is held, and anything else may change freely.
  task automatic gen_advance();
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        if (d_t[i] == 2'd2) g_left[i] = -1;
        else g_left[i] = g_left[i] - 1;
        if (g_left[i] < 0) begin
          if ($urandom_range(0, 1) == 1) begin
            g_left[i] = $urandom_range(0, 3); present(i);
          end else go_idle(i);
        end else if ($urandom_range(0, 3) == 0) go_idle(i);
        else present(i);
      end else if (!is_req(d_t[i])) begin
        if (g_left[i] < 0) begin
          if ($urandom_range(0, 2) == 0) begin
            g_left[i] = $urandom_range(0, 3); present(i);
          end else go_idle(i);
        end else if ($urandom_range(0, 1) == 0) present(i);
      end
    end
    bus_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic script_advance();
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      if (sq[i].size() > 0) begin
        d_t[i] = sq[i][0];
        d_w[i] = W'(i * 256 + sq[i].size());
        d_e[i] = 1'b1;
      end else begin
        d_t[i] = 2'd0; d_w[i] = '0; d_e[i] = 1'b0;
      end
    end
  endtask

  task automatic run_script(input int stall_from, input int stall_len);
    int left;
    log_t.delete(); log_s.delete();
    logging = 1'b1;
    exp_rdy = '0;
    script_advance();
    for (int c = 0; c < 12; c++) begin
      bus_rdy = !(c >= stall_from && c < stall_from + stall_len);
      if (!bus_rdy) begin
        #1;
        check("stall_req_rdy", req_rdy, '0);
      end
      step();
      script_advance();
    end
    logging = 1'b0;
    bus_rdy = 1'b1;
    left = 0;
    for (int i = 0; i < N; i++) left += sq[i].size();
    check("script_drained", left, 0);
  endtask

  function automatic int count_busy();
    int n = 0;
    foreach (log_t[k]) if (log_t[k] != 2'd0) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int f;
    int et [6];
    int es [6];

    // ---- single DONE from requester 2, then the pointer moves to 3 and wraps ----
    do_reset();
    d_t[2] = 2'd2; d_w[2] = 36'h5A5A5A5A5; d_e[2] = 1'b1;
    #1 check("t1_req_rdy", req_rdy, 4'b0100);
    step();
    check("t1_bus_type", bus_cycle_type, 2'd2);
    check("t1_bus_wdat", bus_wdat, 36'h5A5A5A5A5);
    check("t1_bus_src", bus_src_id, 2'd2);
    d_t[2] = 2'd0; d_t[0] = 2'd2; d_t[3] = 2'd2;
    #1 check("t1_ptr_is_3", req_rdy, 4'b1000);
    step();
    d_t[3] = 2'd0;
    #1 check("t1_ptr_wraps", req_rdy, 4'b0001);
    step();
    d_t[0] = 2'd0;
    step();

    // ---- two back-to-back bursts with no interleave and no gap ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sq[i].push_back(2'd1); sq[i].push_back(2'd1); sq[i].push_back(2'd2);
    end
    run_script(99, 0);
    et = '{1, 1, 2, 1, 1, 2};
    es = '{0, 0, 0, 1, 1, 1};
    f = -1;
    foreach (log_t[k]) if (f < 0 && log_t[k] != 2'd0) f = k;
    check("t2_busy_cycles", count_busy(), 6);
    if (f < 0) f = 0;
    for (int k = 0; k < 6; k++) begin
      if (f + k < log_t.size()) begin
        check("t2_seq_type", log_t[f + k], et[k]);
        check("t2_seq_src", log_s[f + k], es[k]);
      end else check("t2_seq_len", f + k, log_t.size() - 1);
    end

    // ---- back-pressure during a burst from requester 1 ----
    do_reset();
    repeat (4) sq[1].push_back(2'd1);
    sq[1].push_back(2'd2);
    run_script(2, 3);
    // Five accepted cycles plus three cycles of holding VALID #2.
    check("t3_busy_cycles", count_busy(), 8);

    // ---- all four requesters issue DONEs continuously ----
    do_reset();
    for (int i = 0; i < N; i++) begin d_t[i] = 2'd2; rand_data(i); end
    for (int k = 0; k < 8; k++) begin
      #1 check("t4_rr_order", req_rdy, 4'b0001 << (k % 4));
      step();
    end

    // ---- reset during a burst of requester 3 ----
    do_reset();
    d_t[3] = 2'd1; rand_data(3);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_type", bus_cycle_type, 2'd0);
    check("t5_rst_wdat", bus_wdat, '0);
    do_reset();
    d_t[0] = 2'd2; d_t[3] = 2'd2; rand_data(0); rand_data(3);
    #1 check("t5_req0_first", req_rdy, 4'b0001);
    step();
    d_t[0] = 2'd0; d_t[3] = 2'd0;
    step();

`ifdef HERO_BUS_ARB_WATCHDOG_EN
    // ---- watchdog: the owner goes quiet after one VALID ----
    do_reset();
    d_t[1] = 2'd1; rand_data(1);
    d_t[2] = 2'd2; rand_data(2);
    step();
    d_t[1] = 2'd0;
    repeat (TO + 1) step();
    check("wd_inject_type", bus_cycle_type, 2'd2);
    check("wd_inject_wdat", bus_wdat, '0);
    check("wd_inject_src", bus_src_id, 2'd1);
    check("wd_abort_pulse", wd_abort, 1'b1);
    #1 check("wd_next_winner", req_rdy, 4'b0100);
    step();
    check("wd_abort_clear", wd_abort, 1'b0);
    d_t[2] = 2'd0;
    step();
`endif

    // ---- randomized traffic with back-pressure ----
    do_reset();
    exp_rdy = '0;
    gen_advance();
    for (int c = 0; c < 3000; c++) begin
      step();
      gen_advance();
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/hero_bus_arbiter.md
Name: hero_bus_arbiter

Overview:
- Shares one hero write bus among NUM_REQ requesters.
- Each requester drives a hero write (cycle_type, wdat, clk_en) as a transaction: zero or more VALID cycles followed by one DONE cycle.
- Arbitration is round-robin between transactions. Once a requester wins, it owns the bus until it completes a DONE; no interleaving.
- Sits between the hero producers and the single registered hero bus toward the bag datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- HERO_WIDTH, 36, width of wdat
- TIMEOUT_CYCLES, 16, watchdog idle limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_cycle_type  in  NUM_REQ*2  per-requester cycle type: 0=IDLE, 1=VALID, 2=DONE, 3 treated as IDLE
- req_wdat  in  NUM_REQ*HERO_WIDTH  per-requester write data
- req_clk_en  in  NUM_REQ  per-requester clock enable
- req_rdy  out  NUM_REQ  requester's current cycle accepted this clock
- bus_rdy  in  1  downstream accepts the current bus cycle
- bus_cycle_type  out  2  registered hero cycle type
- bus_wdat  out  HERO_WIDTH  registered write data
- bus_clk_en  out  1  registered clock enable
- bus_src_id  out  clog2(NUM_REQ)  owner of the current bus cycle
- wd_abort  out  1  one-cycle pulse on a watchdog abort (tied 0 without the feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, so bus_cycle_type=IDLE; state=ARB_IDLE; rr_ptr=0; watchdog counter 0.
- Output stage:
  - out_busy = (bus_cycle_type != IDLE).
  - can_acc = !out_busy || bus_rdy.
  - When !can_acc, all bus_* outputs hold and every req_rdy=0.
  - When can_acc and nothing is accepted, bus_cycle_type loads IDLE; wdat/clk_en load 0.
- Request: a requester is requesting when its cycle_type is VALID or DONE.
- ARB_IDLE:
  - Combinationally pick the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  - If can_acc, assert req_rdy for that index only and load its cycle into the bus registers, with bus_src_id = index.
  - Picked cycle is VALID: go to ARB_BURST with owner = index.
  - Picked cycle is DONE (single-cycle transaction): stay in ARB_IDLE and set rr_ptr = index+1 (mod NUM_REQ).
- ARB_BURST:
  - Only the owner is considered; other requesters see req_rdy=0.
  - Owner VALID and can_acc: forward it and stay.
  - Owner IDLE: bus loads IDLE (a gap); stay.
  - Owner DONE and can_acc: forward it, go to ARB_IDLE, set rr_ptr = owner+1.
- Latency: a cycle accepted at edge t appears on bus_* after edge t; one register stage, no bubble between back-to-back transactions.
- Requester contract: hold the presented cycle until req_rdy. Changing a non-accepted cycle is legal; the arbiter samples whatever is present at acceptance.
- Wrap-around: rr_ptr increments modulo NUM_REQ (NUM_REQ-1 wraps to 0).
- Reset mid-burst: everything returns to reset values immediately; the partial transaction is dropped and the bus shows IDLE.

Optional Feature:
- Macro: HERO_BUS_ARB_WATCHDOG_EN.
- With the macro:
  - In ARB_BURST, a counter counts consecutive cycles in which the owner presents IDLE; it clears on any owner VALID or DONE, and when leaving ARB_BURST.
  - When the counter reaches TIMEOUT_CYCLES and can_acc, the arbiter injects bus_cycle_type=DONE with bus_wdat=0, bus_clk_en=0 and bus_src_id=owner.
  - It pulses wd_abort for one cycle, goes to ARB_IDLE and sets rr_ptr=owner+1.
- Without the macro: no counter; wd_abort is tied 0; a burst lasts indefinitely.

Test Plan:
- Reset, then requester 2 drives DONE wdat=0x5A5A5A5A5 with bus_rdy=1 → req_rdy=4'b0100 that cycle; next cycle bus_cycle_type=DONE, bus_wdat=0x5A5A5A5A5, bus_src_id=2; then rr_ptr=3.
- Requesters 0 and 1 both drive VALID,VALID,DONE from rr_ptr=0 → bus carries req0's three cycles, then req1's three cycles back-to-back with no interleave and no idle cycle between them.
- Owner 1 mid-burst and bus_rdy=0 for 3 cycles → bus_* held constant, req_rdy=0 on all requesters; resumes on bus_rdy=1 with no data lost or duplicated.
- All 4 requesters issue single DONE cycles continuously → grant order 0,1,2,3,0 (wrap), one grant per cycle.
- Reset asserted during req3 burst after 2 VALID cycles → bus_cycle_type=IDLE immediately; after reset, req0 wins first.
- With HERO_BUS_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16: owner sends VALID then IDLE for 16 cycles → injected DONE with wdat=0, wd_abort pulses one cycle, and another requester can then win.
